// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking (parity_err stays 0 otherwise).
module uart_rx #(
  parameter int SYS_CLK_FRE = 100_000_000,
  parameter int BPS         = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int BPS_CNT = SYS_CLK_FRE / BPS;
  localparam logic [15:0] FULL_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(BPS_CNT / 2 - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;

  logic        rxd_sync1;
  logic        rxd_sync2;
  logic        rxd_prev;
  logic [2:0]  state;
  logic [15:0] clk_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        deliver;
  logic        fall;
  logic        half_hit;
  logic        full_hit;
  logic        par_bad;

`ifdef UART_RX_PARITY_EN
  logic        par_bit;
  logic        perr_q;
`endif

  assign fall     = rxd_prev & ~rxd_sync2;
  assign half_hit = (clk_cnt == HALF_LAST);
  assign full_hit = (clk_cnt == FULL_LAST);
  assign rx_busy  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  assign par_bad    = ^{shift, par_bit};
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser plus a delay flop for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_sync1 <= 1'b1;
      rxd_sync2 <= 1'b1;
      rxd_prev  <= 1'b1;
    end else begin
      rxd_sync1 <= uart_rxd;
      rxd_sync2 <= rxd_sync1;
      rxd_prev  <= rxd_sync2;
    end
  end

  // Frame FSM: start check, centre sampling, stop/parity verdict
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      clk_cnt   <= 16'd0;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
`endif
      clk_cnt   <= clk_cnt + 16'd1;
      unique case (state)
        IDLE: begin
          clk_cnt <= 16'd0;
          bit_cnt <= 4'd0;
          if (fall)
            state <= START;
        end
        START: begin
          if (half_hit) begin
            clk_cnt <= 16'd0;
            state   <= rxd_sync2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (full_hit) begin
            clk_cnt <= 16'd0;
            shift[bit_cnt[2:0]] <= rxd_sync2;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (full_hit) begin
            clk_cnt <= 16'd0;
            par_bit <= rxd_sync2;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (full_hit) begin
            clk_cnt <= 16'd0;
            if (!rxd_sync2) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_q <= 1'b1;
`endif
              state  <= IDLE;
            end else begin
              deliver <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        BREAK: begin
          clk_cnt <= 16'd0;
          if (rxd_sync2)
            state <= IDLE;
        end
        default: begin
          clk_cnt <= 16'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // One-entry holding register with overrun on a full slot
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
